// File: rtl/high_bit_search_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : high_bit_search_seq                                             |
// | Purpose  : Sequenced highest-set-bit finder; scans a wide word one chunk   |
// |            per clock from the MSB slice. Optional macro HBS_ZERO_BYPASS_EN |
// |            sends an all-zero word straight to DONE.                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module high_bit_search_seq #(
    parameter int DATA_WIDTH  = 64,
    parameter int CHUNK_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         input_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(DATA_WIDTH)-1:0] out_index,
    output logic                          out_found,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = $clog2(DATA_WIDTH);
    localparam int CNT_W      = $clog2(NUM_CHUNKS);
    localparam logic [CNT_W-1:0] C_CNT_TOP = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        out_index_q, out_index_d;
    logic                    out_found_q, out_found_d;

    logic [CHUNK_WIDTH-1:0]  w_slice;
    logic                    w_slice_nz;
    logic [IDX_W-1:0]        w_local_idx;
    logic [IDX_W-1:0]        w_global_idx;

    // Single chunk-wide priority search, shared across all slices over time.
    always_comb begin
        w_slice     = word_q[cnt_q*CHUNK_WIDTH +: CHUNK_WIDTH];
        w_slice_nz  = |w_slice;
        w_local_idx = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            if (w_slice[i]) begin
                w_local_idx = IDX_W'(i);
            end
        end
        w_global_idx = IDX_W'(cnt_q) * IDX_W'(CHUNK_WIDTH) + w_local_idx;
    end

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        out_index_d = out_index_q;
        out_found_d = out_found_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    word_d  = input_data;
                    cnt_d   = C_CNT_TOP;
                    state_d = ST_SCAN;
`ifdef HBS_ZERO_BYPASS_EN
                    if (input_data == '0) begin
                        out_index_d = '0;
                        out_found_d = 1'b0;
                        state_d     = ST_DONE;
                    end
`endif
                end
            end
            ST_SCAN: begin
                if (w_slice_nz) begin
                    out_index_d = w_global_idx;
                    out_found_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (cnt_q == '0) begin
                    out_index_d = '0;
                    out_found_d = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            cnt_q       <= C_CNT_TOP;
            out_index_q <= '0;
            out_found_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            out_index_q <= out_index_d;
            out_found_q <= out_found_d;
        end
    end

    // Handshake flags come straight from the state register.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_index = out_index_q;
    assign out_found = out_found_q;

endmodule
`default_nettype wire
